// File: rtl/hs_mem_spram_ctrl_pkg.sv
// Shared types for the hs_mem_spram requester controller and its response buffer.
package hs_mem_spram_ctrl_pkg;
   localparam int RSP_BUF_DEPTH = 2;
   typedef logic [1:0] occ_t;
endpackage

// File: rtl/hs_mem_spram_ctrl_rsp_buf.sv
// Two-entry response FIFO; entry 0 is always the head, so the head needs no read pointer.
module hs_mem_spram_ctrl_rsp_buf
   import hs_mem_spram_ctrl_pkg::*;
#(
   parameter type ENTRY_T = logic [7:0]
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   push,
   input  ENTRY_T push_data,
   input  logic   pop,
   output ENTRY_T head,
   output occ_t   cnt
);

   ENTRY_T ent [RSP_BUF_DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt    <= '0;
         ent[0] <= '0;
         ent[1] <= '0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (cnt == 2'd0) ent[0] <= push_data;
               else             ent[1] <= push_data;
               cnt <= cnt + 2'd1;
            end
            2'b01: begin
               ent[0] <= ent[1];
               cnt    <= cnt - 2'd1;
            end
            2'b11: begin
               // Simultaneous pop/push: the new item lands behind whatever survives the pop.
               if (cnt == 2'd1) begin
                  ent[0] <= push_data;
               end else begin
                  ent[0] <= ent[1];
                  ent[1] <= push_data;
               end
            end
            default: ;
         endcase
      end
   end

   assign head = ent[0];

endmodule

// File: rtl/hs_mem_spram_ctrl.sv
// Valid/ready front end for one hs_mem_spram; define HS_MEM_SPRAM_CTRL_WR_ACK_EN to
// make writes return a response carrying the old RAM contents with rsp_wr set.
module hs_mem_spram_ctrl
   import hs_mem_spram_ctrl_pkg::*;
#(
   parameter type DATA_TYPE  = logic [7:0],
   parameter int  DATA_DEPTH = 16,
   localparam int ADDR_WIDTH = $clog2(DATA_DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  DATA_TYPE              req_wdata,
   input  logic                  req_wen,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output DATA_TYPE              rsp_rdata,
   output logic                  rsp_wr,
   output logic                  ram_ce,
   output logic                  ram_wen,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output DATA_TYPE              ram_wdata,
   input  DATA_TYPE              ram_rdata
);

`ifdef HS_MEM_SPRAM_CTRL_WR_ACK_EN
   typedef struct packed {
      logic     wr;
      DATA_TYPE data;
   } rsp_ent_t;
`else
   typedef DATA_TYPE rsp_ent_t;
`endif

   logic       inflight;
   occ_t       cnt;
   logic [2:0] occ;
   logic       acc;
   logic       push;
   logic       pop;
   rsp_ent_t   push_ent;
   rsp_ent_t   head_ent;

   // Occupancy counts the RAM read in flight so the buffer can always absorb it.
   assign occ       = {1'b0, cnt} + {2'b00, inflight};
   assign req_ready = !rst && (occ < 3'(RSP_BUF_DEPTH));
   assign acc       = req_valid && req_ready;

   assign ram_ce    = acc;
   assign ram_wen   = req_wen;
   assign ram_addr  = req_addr;
   assign ram_wdata = req_wdata;

   assign rsp_valid = (cnt != 2'd0) || inflight;
   assign pop       = (cnt != 2'd0) && rsp_ready;
   assign push      = inflight && !((cnt == 2'd0) && rsp_ready);

`ifdef HS_MEM_SPRAM_CTRL_WR_ACK_EN
   logic inflight_wr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inflight    <= 1'b0;
         inflight_wr <= 1'b0;
      end else begin
         inflight    <= acc;
         inflight_wr <= acc && req_wen;
      end
   end

   assign push_ent  = {inflight_wr, ram_rdata};
   assign rsp_rdata = (cnt != 2'd0) ? head_ent.data : ram_rdata;
   assign rsp_wr    = (cnt != 2'd0) ? head_ent.wr   : inflight_wr;
`else
   always_ff @(posedge clk or posedge rst) begin
      if (rst) inflight <= 1'b0;
      else     inflight <= acc && !req_wen;
   end

   assign push_ent  = ram_rdata;
   assign rsp_rdata = (cnt != 2'd0) ? head_ent : ram_rdata;
   assign rsp_wr    = 1'b0;
`endif

   hs_mem_spram_ctrl_rsp_buf #(
      .ENTRY_T (rsp_ent_t)
   ) u_rsp_buf (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_ent),
      .pop       (pop),
      .head      (head_ent),
      .cnt       (cnt)
   );

endmodule

// File: tb/tb_hs_mem_spram_ctrl.sv
// Bench for hs_mem_spram_ctrl with a latency-1 read-before-write RAM model attached.
module tb_hs_mem_spram_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic [3:0] req_addr = '0;
   logic [7:0] req_wdata = '0;
   logic       req_wen = 1'b0;
   logic       rsp_valid;
   logic       rsp_ready = 1'b0;
   logic [7:0] rsp_rdata;
   logic       rsp_wr;
   logic       ram_ce;
   logic       ram_wen;
   logic [3:0] ram_addr;
   logic [7:0] ram_wdata;
   logic [7:0] ram_rdata;

   hs_mem_spram_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_wen   (req_wen),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_wr    (rsp_wr),
      .ram_ce    (ram_ce),
      .ram_wen   (ram_wen),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata)
   );

   always #5 clk = ~clk;

   // RAM: read-before-write, output held while ce is low.
   logic [7:0] ram_mem [16];
   always @(posedge clk) begin
      if (ram_ce) begin
         ram_rdata <= ram_mem[ram_addr];
         if (ram_wen) ram_mem[ram_addr] <= ram_wdata;
      end
   end

   // Reference: memory image plus an ordered list of owed responses {unknown, wr, data}.
   logic [7:0] mdl   [16];
   logic       known [16];
   logic [9:0] q [$];
   int n_cmp = 0;
   int n_err = 0;
   int n_hs  = 0;
   int n_acc = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cycle(input logic v, input logic w, input logic [3:0] a,
                        input logic [7:0] d, input logic rr);
      logic [9:0] e;
      logic       exp_rdy;
      @(negedge clk);
      req_valid = v; req_wen = w; req_addr = a; req_wdata = d; rsp_ready = rr;
      #1;
      exp_rdy = (q.size() < 2);
      chk("req_ready", req_ready, exp_rdy);
      chk("rsp_valid", rsp_valid, q.size() != 0);
      chk("ram_ce", ram_ce, v && exp_rdy);
      if (v && exp_rdy) begin
         chk("ram_addr", ram_addr, a);
         chk("ram_wen", ram_wen, w);
         if (w) chk("ram_wdata", ram_wdata, d);
      end
      if (q.size() != 0) begin
         e = q[0];
         if (!e[9]) chk("rsp_rdata", rsp_rdata, e[7:0]);
         chk("rsp_wr", rsp_wr, e[8]);
         if (rr) void'(q.pop_front());
      end
      if (rsp_valid && rsp_ready) n_hs++;
      if (req_valid && req_ready) n_acc++;
      if (v && exp_rdy) begin
         if (w) begin
`ifdef HS_MEM_SPRAM_CTRL_WR_ACK_EN
            q.push_back({!known[a], 1'b1, mdl[a]});
`endif
            mdl[a]   = d;
            known[a] = 1'b1;
         end else begin
            q.push_back({!known[a], 1'b0, mdl[a]});
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      req_valid = 1'b1;
      req_wen = 1'b0;
      rsp_ready = 1'b1;
      q.delete();
      #1;
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_req_ready", req_ready, 1'b0);
      chk("rst_ram_ce", ram_ce, 1'b0);
      @(negedge clk);
      #1;
      chk("rst_hold_ram_ce", ram_ce, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      req_valid = 1'b0;
      #1;
      chk("post_rst_req_ready", req_ready, 1'b1);
      chk("post_rst_rsp_valid", rsp_valid, 1'b0);
   endtask

   typedef struct {
      logic       v;
      logic [3:0] a;
      logic       rr;
      logic       e_ready;
      logic       e_valid;
      logic [7:0] e_rdata;
   } vec_t;

   vec_t bp [8];

   initial begin
      // Backpressure: two reads fill the pipe, the third waits for a drain.
      bp[0] = '{1'b1, 4'd3, 1'b0, 1'b1, 1'b0, 8'h00};
      bp[1] = '{1'b1, 4'd4, 1'b0, 1'b1, 1'b1, 8'hA3};
      bp[2] = '{1'b1, 4'd5, 1'b0, 1'b0, 1'b1, 8'hA3};
      bp[3] = '{1'b1, 4'd5, 1'b0, 1'b0, 1'b1, 8'hA3};
      bp[4] = '{1'b1, 4'd5, 1'b1, 1'b0, 1'b1, 8'hA3};
      bp[5] = '{1'b1, 4'd5, 1'b1, 1'b1, 1'b1, 8'hA4};
      bp[6] = '{1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 8'hA5};
      bp[7] = '{1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 8'h00};

      for (int i = 0; i < 16; i++) known[i] = 1'b0;

      @(negedge clk);
      #1;
      chk("init_req_ready", req_ready, 1'b0);
      chk("init_rsp_valid", rsp_valid, 1'b0);
      chk("init_ram_ce", ram_ce, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      // Back-to-back writes then reads.
      for (int i = 0; i < 16; i++) cycle(1'b1, 1'b1, 4'(i), 8'hA0 + 8'(i), 1'b1);
      cycle(1'b0, 1'b0, 4'd0, 8'h00, 1'b1);
      n_hs = 0;
      for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 4'(i), 8'h00, 1'b1);
      cycle(1'b0, 1'b0, 4'd0, 8'h00, 1'b1);
      chk("b2b_rsp_count", n_hs, 16);
      cycle(1'b0, 1'b0, 4'd0, 8'h00, 1'b1);

      for (int i = 0; i < 8; i++) begin
         cycle(bp[i].v, 1'b0, bp[i].a, 8'h00, bp[i].rr);
         chk("bp_req_ready", req_ready, bp[i].e_ready);
         chk("bp_rsp_valid", rsp_valid, bp[i].e_valid);
         if (bp[i].e_valid) chk("bp_rsp_rdata", rsp_rdata, bp[i].e_rdata);
      end

`ifdef HS_MEM_SPRAM_CTRL_WR_ACK_EN
      cycle(1'b1, 1'b1, 4'd7, 8'h55, 1'b1);
      cycle(1'b0, 1'b0, 4'd0, 8'h00, 1'b1);
      chk("wack_valid", rsp_valid, 1'b1);
      chk("wack_wr", rsp_wr, 1'b1);
      chk("wack_old_data", rsp_rdata, 8'hA7);
      cycle(1'b1, 1'b0, 4'd7, 8'h00, 1'b1);
      cycle(1'b0, 1'b0, 4'd0, 8'h00, 1'b1);
      chk("wack_rb_wr", rsp_wr, 1'b0);
      chk("wack_rb_data", rsp_rdata, 8'h55);
      cycle(1'b0, 1'b0, 4'd0, 8'h00, 1'b1);
`else
      n_acc = 0;
      for (int i = 0; i < 8; i++) begin
         cycle(1'b1, 1'b1, 4'(8 + i), 8'hC0 + 8'(i), 1'b0);
         chk("wr_no_rsp_valid", rsp_valid, 1'b0);
      end
      chk("wr_accepted", n_acc, 8);
      for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 4'(8 + i), 8'hA8 + 8'(i), 1'b1);
`endif

      // Random traffic with a reset dropped in mid-stream.
      for (int i = 0; i < 10000; i++) begin
         if (i == 5000) begin
            do_reset();
            for (int k = 0; k < 16; k++) cycle(1'b1, 1'b0, 4'(k), 8'h00, 1'b1);
         end
         cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
               4'($urandom_range(0, 15)), 8'($urandom), 1'($urandom_range(0, 1)));
      end
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 4'd0, 8'h00, 1'b1);
      chk("drain_empty", rsp_valid, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/hs_mem_spram_ctrl.md
# hs_mem_spram_ctrl

Requester-side controller for the single-port, latency-1 RAM `hs_mem_spram`. It converts a valid/ready request stream (read or write) into RAM port cycles. Read data returns on an in-order valid/ready response stream with full backpressure, and the block never loses a RAM read. It sits between any streaming master (DMA, CPU bridge, table walker) and one `hs_mem_spram` instance.

## Interface
- `DATA_TYPE`, default `logic[7:0]`: RAM item type; must match the attached RAM.
- `DATA_DEPTH`, default 16: RAM depth; must match the attached RAM.
- `ADDR_WIDTH`, local, `$clog2(DATA_DEPTH)`.
- `clk`, in, 1: single clock.
- `rst`, in, 1: reset, asynchronous and active-high.
- `req_valid`, in, 1: request present.
- `req_ready`, out, 1: request accepted when `req_valid && req_ready`.
- `req_addr`, in, `ADDR_WIDTH`: access address.
- `req_wdata`, in, `DATA_TYPE`: write data.
- `req_wen`, in, 1: 1 = write, 0 = read.
- `rsp_valid`, out, 1: response present.
- `rsp_ready`, in, 1: response consumed when `rsp_valid && rsp_ready`.
- `rsp_rdata`, out, `DATA_TYPE`: read data.
- `rsp_wr`, out, 1: response belongs to a write; constant 0 unless `HS_MEM_SPRAM_CTRL_WR_ACK_EN` is defined.
- `ram_ce`, `ram_wen`, out, 1: RAM clock enable and write enable.
- `ram_addr`, out, `ADDR_WIDTH`: RAM address.
- `ram_wdata`, out, `DATA_TYPE`: RAM write data.
- `ram_rdata`, in, `DATA_TYPE`: RAM read data, valid one cycle after a `ram_ce` cycle.

## Operation
- Accept: `acc = req_valid && req_ready`.
  - `ram_ce = acc`.
  - `ram_addr`, `ram_wdata` and `ram_wen` pass through combinationally from `req_*`.
- Write: committed to the RAM in the accept cycle. It produces no response unless the macro is defined.
- Read: sets the register `inflight` for one cycle. In the following cycle `ram_rdata` is the response data.
- Response buffer: 2-entry fall-through FIFO, count `cnt` in 0..2.
  - `rsp_valid = (cnt != 0) || inflight`.
  - `rsp_rdata` = buffer head if `cnt != 0`, else `ram_rdata`.
  - If `inflight` and the response is not taken directly from `ram_rdata`, `ram_rdata` is pushed into the buffer in that same cycle.
  - Pop and push in the same cycle keeps `cnt` unchanged.
- Flow control: `req_ready = !rst && (cnt + inflight < 2)`.
  - `req_ready` depends on registered state only; there is no `rsp_ready` to `req_ready` path.
  - This guarantees the buffer never overflows.
- Ordering: responses leave strictly in request order.
- Reset values: `cnt = 0`, `inflight = 0`, `rsp_valid = 0`, `req_ready = 0` while `rst` is high and 1 after release, `ram_ce = 0` while `rst` is high.
- Reset mid-operation: in-flight and buffered responses are discarded. Writes already issued remain in the RAM, which is not reset.

## Timing
- Read latency: accept at cycle t gives `rsp_valid` at t+1 when the buffer is empty and `rsp_ready` is held high.
- Throughput: one request per cycle sustained while `rsp_ready` stays high.
- Stall: with `rsp_ready` low, at most 2 reads are accepted. `req_ready` drops in the cycle after `cnt + inflight` reaches 2.
- Response drain: when `rsp_ready` rises, `req_ready` recovers in the cycle after the pop that lowers occupancy below 2.
- RAM contract: `ram_rdata` is sampled only in the cycle after a read issue. The RAM holds `rdata` while `ce = 0`, but the block does not rely on this.

## Configuration
- `HS_MEM_SPRAM_CTRL_WR_ACK_EN` defined:
  - Writes also set `inflight` and produce a response.
  - The write response has `rsp_wr = 1` and `rsp_rdata` = the old RAM contents, because the RAM performs read-before-write.
  - Writes are subject to the same occupancy limit as reads.
- Not defined:
  - Writes set no state and are accepted whenever `req_ready` is high.
  - `rsp_wr` is tied to 0.
  - The buffer stores data only.

## Structure
- Package `hs_mem_spram_ctrl_pkg` holds:
  - `localparam int RSP_BUF_DEPTH = 2`.
  - `typedef logic [1:0] occ_t` for occupancy.
- Sub-module `hs_mem_spram_ctrl_rsp_buf`: 2-entry fall-through FIFO, parameterised by the entry type (`DATA_TYPE`, plus the `wr` bit when the macro is defined). The top level holds `inflight` and the accept logic.

## Test plan
- Reset: `rst` high mid-traffic → `rsp_valid = 0`, `req_ready = 0`, `ram_ce = 0`. After release, `req_ready = 1`, and earlier RAM writes read back intact.
- Back-to-back: write addr 0..15 with data `0xA0+i`, then read 0..15 with `rsp_ready = 1` → 16 responses `0xA0..0xAF` in order, one per cycle, first at accept+1.
- Backpressure: `rsp_ready = 0`, issue reads of addr 3, 4, 5 → only 2 accepted, `req_ready = 0`. Raise `rsp_ready` → `0xA3` then `0xA4`, then the addr 5 read is accepted.
- Random stall: random `req_valid` / `rsp_ready` over 10k cycles against a reference model → no loss, duplication or reordering, and `cnt` never exceeds 2.
- Macro defined: write 0x55 to addr 7 holding 0xA7 → response `rsp_wr = 1`, `rsp_rdata = 0xA7`. A following read of addr 7 returns 0x55.
- Macro undefined: 8 consecutive writes with `rsp_ready = 0` → all accepted, `rsp_valid` stays 0.
